// File: rtl/alu_mul_pkg.sv
// Shared constants and types for the shift-and-add multiplier controller.
package alu_mul_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned ALU_CTRL_W = 6;

  // ALU control word {zx, nx, zy, ny, f, no} selecting x+y
  localparam logic [ALU_CTRL_W-1:0] ALU_CODE_ADD = 6'b000010;

  // Final iteration index of the 16-step multiply
  localparam logic [CNT_W-1:0] CNT_LAST = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : alu_mul_pkg

// File: rtl/alu_mul_ctrl.sv
// Sequential 16x16 (low half) multiplier that borrows an external ALU for
// the accumulate step: one ALU add per cycle, shift-and-add on MC/MP.
// Optional macro ALU_MUL_EARLY_EXIT_EN ends the run as soon as no multiplier
// bits remain; the product is the same either way, only latency changes.
module alu_mul_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zr,
  output logic             res_ng,
  output logic             alu_zx,
  output logic             alu_nx,
  output logic             alu_zy,
  output logic             alu_ny,
  output logic             alu_f,
  output logic             alu_no,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  input  logic [WIDTH-1:0] alu_out
);

  import alu_mul_pkg::*;

  state_e           state;
  state_e           state_nxt;
  logic [WIDTH-1:0] mc;
  logic [WIDTH-1:0] mp;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             run_last;

  assign accept = (state == IDLE) && start_valid;

  // Last RUN cycle: counter terminal, or (optionally) no multiplier bits left
  always_comb begin
    run_last = (cnt == CNT_LAST);
`ifdef ALU_MUL_EARLY_EXIT_EN
    if (mp[WIDTH-1:1] == '0) begin
      run_last = 1'b1;
    end
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_valid) state_nxt = RUN;
      RUN:     if (run_last)    state_nxt = DONE;
      DONE:    if (res_ready)   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture on accept, shift-and-add while running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc  <= '0;
      mp  <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      mc  <= a;
      mp  <= b;
      acc <= '0;
      cnt <= '0;
    end else if (state == RUN) begin
      if (mp[0]) begin
        acc <= alu_out;
      end
      mc  <= {mc[WIDTH-2:0], 1'b0};
      mp  <= {1'b0, mp[WIDTH-1:1]};
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Outputs decoded from state; everything idles at zero outside its state
  always_comb begin
    start_ready = 1'b0;
    res_valid   = 1'b0;
    res_data    = '0;
    res_zr      = 1'b0;
    res_ng      = 1'b0;
    {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = '0;
    alu_x       = '0;
    alu_y       = '0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
      end
      RUN: begin
        {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ALU_CODE_ADD;
        alu_x = acc;
        alu_y = mc;
      end
      DONE: begin
        res_valid = 1'b1;
        res_data  = acc;
        res_zr    = (acc == '0);
        res_ng    = acc[WIDTH-1];
      end
      default: begin
        start_ready = 1'b0;
      end
    endcase
  end

endmodule : alu_mul_ctrl

// File: tb/tb_alu_mul_ctrl.sv
// Bench for alu_mul_ctrl: models the external Hack-style ALU, runs directed
// and random multiplies against an arithmetic reference, checks latency,
// backpressure hold, ignored starts and asynchronous reset.
module tb_alu_mul_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_zr;
  logic        res_ng;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [15:0] alu_out;

  int checks;
  int failures;

  alu_mul_ctrl #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_zr      (res_zr),
    .res_ng      (res_ng),
    .alu_zx      (alu_zx),
    .alu_nx      (alu_nx),
    .alu_zy      (alu_zy),
    .alu_ny      (alu_ny),
    .alu_f       (alu_f),
    .alu_no      (alu_no),
    .alu_x       (alu_x),
    .alu_y       (alu_y),
    .alu_out     (alu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External 16-bit ALU (zx/nx/zy/ny/f/no semantics)
  logic [15:0] ax, ay, af;
  always_comb begin
    ax = alu_zx ? 16'h0000 : alu_x;
    ax = alu_nx ? ~ax : ax;
    ay = alu_zy ? 16'h0000 : alu_y;
    ay = alu_ny ? ~ay : ay;
    af = alu_f ? 16'(ax + ay) : (ax & ay);
    alu_out = alu_no ? ~af : af;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_product(input logic [15:0] av, input logic [15:0] bv);
    longint p;
    p = longint'(av) * longint'(bv);
    return 16'(p % 65536);
  endfunction

  // Edges from accept (inclusive) until res_valid is visible
  function automatic int ref_latency(input logic [15:0] bv);
`ifdef ALU_MUL_EARLY_EXIT_EN
    int k;
    k = 1;
    for (int i = 0; i < 16; i++) begin
      if (bv[i]) k = i + 1;
    end
    return k + 1;
`else
    if (bv == 16'hFFFF) return 17;
    return 17;
`endif
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_start_ready"}, 32'(start_ready), 32'd1);
    check_eq({tag, "_res_valid"},   32'(res_valid),   32'd0);
    check_eq({tag, "_res_data"},    32'(res_data),    32'd0);
    check_eq({tag, "_res_flags"},   32'({res_zr, res_ng}), 32'd0);
    check_eq({tag, "_alu_ctrl"},
             32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}), 32'd0);
    check_eq({tag, "_alu_xy"},      {alu_x, alu_y}, 32'd0);
  endtask

  task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input int stall);
    logic [15:0] exp;
    logic [15:0] held;
    int          lat;
    exp = ref_product(av, bv);
    @(negedge clk);
    check_eq("offer_start_ready", 32'(start_ready), 32'd1);
    start_valid = 1'b1;
    a = av;
    b = bv;
    res_ready = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    if (!res_valid) begin
      check_eq("run_alu_ctrl",
               32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}), 32'b000010);
      check_eq("run_start_ready", 32'(start_ready), 32'd0);
    end
    while (!res_valid && lat < 40) begin
      start_valid = 1'($urandom_range(0, 1));
      @(posedge clk);
      lat++;
      @(negedge clk);
      start_valid = 1'b0;
    end
    if (!res_valid) begin
      check_eq("timeout_res_valid", 32'(res_valid), 32'd1);
      return;
    end
    check_eq("latency", 32'(lat), 32'(ref_latency(bv)));
    check_eq("res_data", 32'(res_data), 32'(exp));
    check_eq("res_zr", 32'(res_zr), 32'(exp == 16'h0000));
    check_eq("res_ng", 32'(res_ng), 32'(exp[15]));
    check_eq("done_start_ready", 32'(start_ready), 32'd0);
    held = res_data;
    for (int i = 0; i < stall; i++) begin
      start_valid = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      check_eq("stall_res_valid", 32'(res_valid), 32'd1);
      check_eq("stall_res_data", 32'(res_data), 32'(held));
      check_eq("stall_start_ready", 32'(start_ready), 32'd0);
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check_eq("handoff_res_valid", 32'(res_valid), 32'd0);
    check_eq("handoff_start_ready", 32'(start_ready), 32'd1);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    start_valid = 1'b0;
    res_ready = 1'b0;
    a = 16'h0000;
    b = 16'h0000;
    #1;
    check_idle_outputs("in_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_reset");

    do_op(16'd3, 16'd5, 0);
    do_op(16'hFFFF, 16'hFFFF, 0);
    do_op(16'd300, 16'd300, 1);
    do_op(16'h4000, 16'd2, 0);
    do_op(16'h1234, 16'd0, 0);
    do_op(16'd7, 16'd1, 0);
    do_op(16'd7, 16'h8000, 0);
    do_op(16'hBEEF, 16'h1357, 10);

    // Asynchronous reset in the middle of a run
    @(negedge clk);
    start_valid = 1'b1;
    a = 16'h1234;
    b = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_run_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_mid_reset");
    do_op(16'd7, 16'd6, 0);

    for (int n = 0; n < 20; n++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (n % 5 == 0) rb = rb >> $urandom_range(0, 15);
      do_op(ra, rb, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_alu_mul_ctrl
